spi_target: RTL

SPI responder that terminates the 24-bit command frames issued by the SPI controller on the same spi_clk/spi_enb/spi_di/spi_do wires. It oversamples the SPI pins on the system clock, decodes a write-flag/address/data frame, and commits writes to an internal 8-bit register bank or returns register contents MSB-first on spi_do. It sits on the peripheral side of the link and exposes the register bank plus write/read notification pulses to local logic.

---
 rtl/spi_target.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_target.sv
// SPI register target: oversamples the SPI pins, decodes write-flag/address/data frames, serves an 8-bit register bank.
// Latency: pin edge to action SYNC_STAGES+1 clk, write commit SYNC_STAGES+2 clk; no backpressure, the controller sets the pace.
module spi_target #(
    parameter int SPI_ADDR_WIDTH = 16,
    parameter int SPI_CMD_WIDTH  = 24,
    parameter int NUM_REGS       = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     spi_clk,
    input  logic                                     spi_enb,
    input  logic                                     spi_di,
    output logic                                     spi_do,
    output logic                                     wr_vld,
    output logic [SPI_ADDR_WIDTH-2:0]                wr_addr,
    output logic [SPI_CMD_WIDTH-SPI_ADDR_WIDTH-1:0]  wr_data,
    output logic                                     rd_vld,
    output logic                                     frame_err,
    output logic [8*NUM_REGS-1:0]                    reg_q
);
    localparam int AW = SPI_ADDR_WIDTH - 1;
    localparam int DW = SPI_CMD_WIDTH - SPI_ADDR_WIDTH;
    localparam int IW = $clog2(NUM_REGS);
    localparam int CW = $clog2(SPI_CMD_WIDTH + 1);
    localparam logic [CW-1:0] ADDR_LAST  = CW'(SPI_ADDR_WIDTH - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(SPI_CMD_WIDTH - 1);
    localparam logic [CW-1:0] FIRST_RD   = CW'(SPI_ADDR_WIDTH);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, WAIT_END} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] clk_sync, enb_sync, di_sync;
    logic                   clk_prev, enb_prev;
    logic                   clk_s, enb_s, di_s, rise, fall, enb_fall, abort;
    logic [AW-1:0]          shreg;
    logic [AW-1:0]          addr_q;
    logic [CW-1:0]          cnt;
    logic [DW-1:0]          rd_sh;
    logic                   wr_pend, rd_pend;
    logic [DW-1:0]          regs [NUM_REGS];
    logic [AW-1:0]          rd_addr;
    logic                   rd_hit, wr_hit;
    logic [DW-1:0]          rd_byte;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign enb_s    = enb_sync[SYNC_STAGES-1];
    assign di_s     = di_sync[SYNC_STAGES-1];
    assign rise     = clk_s & ~clk_prev;
    assign fall     = ~clk_s & clk_prev;
    assign enb_fall = ~enb_s & enb_prev;
    assign abort    = enb_s && (state == ADDR || state == WDATA || state == RDATA);

    // Address as it will stand once the 16th bit is shifted in.
    assign rd_addr = {shreg[AW-2:0], di_s};
    assign rd_hit  = {1'b0, rd_addr} < (AW+1)'(NUM_REGS);
    assign wr_hit  = {1'b0, addr_q} < (AW+1)'(NUM_REGS);
    assign rd_byte = rd_hit ? regs[rd_addr[IW-1:0]] : '0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
        assign reg_q[8*g +: 8] = regs[g];
    end

    // Sync flops reset low so a frame already in flight at reset release shows no enable edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '0;
            enb_sync <= '0;
            di_sync  <= '0;
            clk_prev <= 1'b0;
            enb_prev <= 1'b0;
            state    <= IDLE;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            enb_sync <= {enb_sync[SYNC_STAGES-2:0], spi_enb};
            di_sync  <= {di_sync[SYNC_STAGES-2:0], spi_di};
            clk_prev <= clk_s;
            enb_prev <= enb_s;
            state    <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (enb_fall) state_nxt = ADDR;
            ADDR:     if (enb_s) state_nxt = IDLE;
                      else if (rise && cnt == ADDR_LAST) state_nxt = shreg[AW-1] ? WDATA : RDATA;
            WDATA,
            RDATA:    if (enb_s) state_nxt = IDLE;
                      else if (rise && cnt == FRAME_LAST) state_nxt = WAIT_END;
            WAIT_END: if (enb_s) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_do    <= 1'b0;
            wr_vld    <= 1'b0;
            rd_vld    <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            shreg     <= '0;
            addr_q    <= '0;
            cnt       <= '0;
            rd_sh     <= '0;
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_vld    <= wr_pend;
            rd_vld    <= rd_pend;
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            frame_err <= abort;
            if (wr_pend) begin
                wr_addr <= addr_q;
                wr_data <= shreg[DW-1:0];
                if (wr_hit) regs[addr_q[IW-1:0]] <= shreg[DW-1:0];
            end
            if (abort) begin
                spi_do <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        spi_do <= 1'b0;
                        if (enb_fall) begin
                            cnt   <= '0;
                            shreg <= '0;
                        end
                    end
                    ADDR, WDATA, RDATA: begin
                        if (rise) begin
                            shreg <= {shreg[AW-2:0], di_s};
                            cnt   <= cnt + 1'b1;
                            if (state == ADDR && cnt == ADDR_LAST) begin
                                addr_q <= rd_addr;
                                if (!shreg[AW-1]) begin
                                    rd_sh  <= rd_byte;
                                    spi_do <= rd_byte[DW-1];
                                end
                            end
                            if (state != ADDR && cnt == FRAME_LAST) begin
                                wr_pend <= (state == WDATA);
                                rd_pend <= (state == RDATA);
                                spi_do  <= 1'b0;
                            end
                        end else if (fall && state == RDATA && cnt > FIRST_RD) begin
                            // The fall right after the last address bit keeps bit 7 up for the first data clock.
                            rd_sh  <= {rd_sh[DW-2:0], 1'b0};
                            spi_do <= rd_sh[DW-2];
                        end
                    end
                    default: spi_do <= 1'b0;
                endcase
            end
        end
    end
endmodule
